fu_mul_pipe: RTL and testbench

FU_MUL_PIPE -- requirements
Module: fu_mul_pipe

---
 rtl/fu_mul_pkg.sv | 11 +
 rtl/fu_mul_core.sv | 80 ++++++++
 rtl/fu_mul_pipe.sv | 105 ++++++++++
 tb/tb_fu_mul_pipe.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fu_mul_pkg.sv
// Shared definitions for the pipelined multiply unit: op encodings.
package fu_mul_pkg;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } fu_op_e;

endpackage

// File: rtl/fu_mul_core.sv
// Multiplier datapath: per-op operand extension and a LAT-1 stage product pipeline.
// With FU_MUL_HIGH_EN undefined only the XLEN-bit low product is built.
module fu_mul_core
  import fu_mul_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int LAT  = 4
) (
  input  logic              clk_i,
  input  logic              en_i,
  input  fu_op_e            op_i,
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  output logic [2*XLEN-1:0] prod_o
);

`ifdef FU_MUL_HIGH_EN
  localparam int OW = XLEN + 1;
  localparam int PW = 2 * XLEN;
`else
  localparam int OW = XLEN;
  localparam int PW = XLEN;
`endif

  logic [OW-1:0] a_d, b_d, a_q, b_q;
  logic [PW-1:0] prod_c, prod_last;

`ifdef FU_MUL_HIGH_EN
  logic signed [2*OW-1:0] a_x, b_x, full;
  logic                   unused_full_hi;

  // One extra bit per operand lets all four ops share a single signed multiply
  always_comb begin
    a_d = {a_i[XLEN-1] & ((op_i == OP_MULH) || (op_i == OP_MULHSU)), a_i};
    b_d = {b_i[XLEN-1] & (op_i == OP_MULH), b_i};
  end

  assign a_x            = {{OW{a_q[OW-1]}}, a_q};
  assign b_x            = {{OW{b_q[OW-1]}}, b_q};
  assign full           = a_x * b_x;
  assign prod_c         = full[PW-1:0];
  assign unused_full_hi = ^full[2*OW-1:PW];
`else
  logic unused_op;

  assign unused_op = ^op_i;
  assign a_d       = a_i;
  assign b_d       = b_i;
  assign prod_c    = a_q * b_q;
`endif

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  if (LAT == 2) begin : g_no_pipe
    assign prod_last = prod_c;
  end else begin : g_pipe
    logic [PW-1:0] pipe_q [LAT-2];

    always_ff @(posedge clk_i) begin
      if (en_i) begin
        pipe_q[0] <= prod_c;
        for (int i = 1; i < LAT - 2; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign prod_last = pipe_q[LAT-3];
  end

`ifdef FU_MUL_HIGH_EN
  assign prod_o = prod_last;
`else
  assign prod_o = {{XLEN{1'b0}}, prod_last};
`endif

endmodule

// File: rtl/fu_mul_pipe.sv
// Pipelined multiply functional unit: valid/tag/op chain, stall/flush control, result half select.
// Define FU_MUL_HIGH_EN to enable MULH/MULHSU/MULHU; otherwise every op returns the low product.
module fu_mul_pipe
  import fu_mul_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int LAT   = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_res,
  output logic [TAG_W-1:0] out_tag
);

  // Core stages run in parallel with the valid/tag chain; the output register is the last stage
  localparam int NS = LAT - 1;

  logic [NS-1:0]     vld_d, vld_q;
  logic [TAG_W-1:0]  tag_q [NS];
  logic              out_valid_q;
  logic [XLEN-1:0]   out_res_q, res_d;
  logic [TAG_W-1:0]  out_tag_q;
  logic [2*XLEN-1:0] prod;
  logic              stall, en, issue;

  assign stall    = out_valid_q & ~out_ready;
  assign en       = ~stall;
  assign in_ready = ~flush & ~stall;
  assign issue    = in_valid & in_ready;

  fu_mul_core #(.XLEN(XLEN), .LAT(LAT)) u_core (
    .clk_i  (clk),
    .en_i   (en),
    .op_i   (fu_op_e'(in_op)),
    .a_i    (in_a),
    .b_i    (in_b),
    .prod_o (prod)
  );

  always_comb begin
    vld_d    = '0;
    vld_d[0] = issue;
    for (int i = 1; i < NS; i++) vld_d[i] = vld_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (en) begin
      tag_q[0] <= in_tag;
      for (int i = 1; i < NS; i++) tag_q[i] <= tag_q[i-1];
    end
  end

`ifdef FU_MUL_HIGH_EN
  fu_op_e op_q [NS];

  always_ff @(posedge clk) begin
    if (en) begin
      op_q[0] <= fu_op_e'(in_op);
      for (int i = 1; i < NS; i++) op_q[i] <= op_q[i-1];
    end
  end

  assign res_d = (op_q[NS-1] == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
`else
  logic unused_hi;

  assign unused_hi = ^prod[2*XLEN-1:XLEN];
  assign res_d     = prod[XLEN-1:0];
`endif

  // Result data only loads with a valid op, so bubbles leave the last result on the bus
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q       <= '0;
      out_valid_q <= 1'b0;
      out_res_q   <= '0;
      out_tag_q   <= '0;
    end else if (flush) begin
      vld_q       <= '0;
      out_valid_q <= 1'b0;
    end else if (en) begin
      vld_q       <= vld_d;
      out_valid_q <= vld_q[NS-1];
      if (vld_q[NS-1]) begin
        out_res_q <= res_d;
        out_tag_q <= tag_q[NS-1];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_res   = out_res_q;
  assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_fu_mul_pipe.sv
// Bench for fu_mul_pipe: vector table plus hand sequences, all results checked through a scoreboard queue.
module tb_fu_mul_pipe;

  localparam int XLEN  = 32;
  localparam int LAT   = 4;
  localparam int TAG_W = 4;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  in_op;
  logic [31:0] in_a, in_b, out_res;
  logic [3:0]  in_tag, out_tag;

  int   n_pass = 0;
  int   n_total = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  bit   rnd_mode = 1'b0;
  vec_t vecs[12];

  fu_mul_pipe #(.XLEN(XLEN), .LAT(LAT), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference product built from the unsigned product plus sign corrections
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] pu;
    logic [31:0] hi;
    pu = {32'b0, a} * {32'b0, b};
    hi = pu[63:32];
`ifdef FU_MUL_HIGH_EN
    case (op)
      2'b00:   return pu[31:0];
      2'b01:   return hi - (a[31] ? b : 32'd0) - (b[31] ? a : 32'd0);
      2'b10:   return hi - (a[31] ? b : 32'd0);
      default: return hi;
    endcase
`else
    if (op == 2'b11) return pu[31:0];
    return pu[31:0] ^ (hi & 32'd0);
`endif
  endfunction

  always @(negedge clk) begin
    if (rst_n && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_out", 1, 0);
      else begin
        mon_e = exp_q.pop_front();
        check("res", out_res, mon_e.res);
        check("tag", out_tag, mon_e.tag);
      end
    end
  end

  always @(posedge clk) begin
    if (rnd_mode) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge, then scrambles inputs
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] tag, input logic [31:0] exp_res);
    bit   acc = 1'b0;
    exp_t e;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      if (in_ready) begin
        e.res = exp_res; e.tag = tag;
        exp_q.push_back(e);
        acc = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_op = 2'($urandom); in_a = $urandom; in_b = $urandom; in_tag = 4'($urandom);
    if (!acc) check("issue_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && exp_q.size() > 0; n++) @(posedge clk);
    #1;
    check("drain_empty", exp_q.size(), 0);
  endtask

  function automatic logic [31:0] pick(input vec_t v);
`ifdef FU_MUL_HIGH_EN
    return v.exp_hi;
`else
    return v.exp_lo;
`endif
  endfunction

  initial begin
    int          cyc, highs;
    logic [31:0] held_res;
    logic [3:0]  held_tag;
    logic [1:0]  op;
    logic [31:0] a, b;

    vecs[0]  = '{2'b00, 32'd7,        32'd6,        4'd3,  32'd42,       32'd42};
    vecs[1]  = '{2'b01, 32'h80000000, 32'h80000000, 4'd1,  32'h40000000, 32'h00000000};
    vecs[2]  = '{2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd2,  32'hFFFFFFFE, 32'h00000001};
    vecs[3]  = '{2'b10, 32'hFFFFFFFF, 32'd2,        4'd4,  32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[4]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd5,  32'h00000001, 32'h00000001};
    vecs[5]  = '{2'b00, 32'h12345678, 32'd0,        4'd6,  32'h00000000, 32'h00000000};
    vecs[6]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd7,  32'h00000000, 32'h00000001};
    vecs[7]  = '{2'b11, 32'h80000000, 32'd2,        4'd8,  32'h00000001, 32'h00000000};
    vecs[8]  = '{2'b10, 32'd2,        32'hFFFFFFFF, 4'd9,  32'h00000001, 32'hFFFFFFFE};
    vecs[9]  = '{2'b00, 32'h0000FFFF, 32'h00010001, 4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[10] = '{2'b01, 32'h7FFFFFFF, 32'h7FFFFFFF, 4'd11, 32'h3FFFFFFF, 32'h00000001};
    vecs[11] = '{2'b01, 32'h80000000, 32'h7FFFFFFF, 4'd12, 32'hC0000000, 32'h80000000};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = 2'b00;
    in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_res", out_res, 0);
    check("rst_out_tag", out_tag, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 1);

    // Single MUL: out_valid must be seen at the consumer edge LAT edges after issue
    issue(2'b00, 32'd7, 32'd6, 4'd3, 32'd42);
    cyc = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk); cyc++;
    end
    check("latency", cyc, LAT - 1);
    @(posedge clk); #1;
    drain();

    // Vector table, back-to-back
    foreach (vecs[i]) issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, pick(vecs[i]));
    drain();

    // Stall with three ops in flight
    out_ready = 1'b0;
    issue(2'b00, 32'd3, 32'd5, 4'd1, 32'd15);
    issue(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd2, model(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF));
    issue(2'b10, 32'hFFFFFFFF, 32'd2, 4'd3, model(2'b10, 32'hFFFFFFFF, 32'd2));
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    check("stall_valid", out_valid, 1);
    held_res = out_res; held_tag = out_tag;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("stall_in_ready", in_ready, 0);
      check("stall_res_hold", out_res, held_res);
      check("stall_tag_hold", out_tag, held_tag);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

    // Flush with two ops in flight and a competing issue request
    issue(2'b00, 32'd11, 32'd13, 4'd4, 32'd143);
    issue(2'b00, 32'd17, 32'd19, 4'd5, 32'd323);
    flush = 1'b1; in_valid = 1'b1; in_op = 2'b00; in_a = 32'd2; in_b = 32'd2; in_tag = 4'd6;
    @(negedge clk);
    check("flush_in_ready", in_ready, 0);
    exp_q.delete();
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    highs = 0;
    for (int n = 0; n < LAT + 2; n++) begin
      @(negedge clk);
      if (out_valid) highs++;
    end
    check("flush_no_out", highs, 0);
    @(posedge clk); #1;
    issue(2'b00, 32'd5, 32'd9, 4'd7, 32'd45);
    drain();

    // Half-cycle reset while a result is stalled at the output
    out_ready = 1'b0;
    issue(2'b00, 32'd21, 32'd2, 4'd8, 32'd42);
    issue(2'b00, 32'd22, 32'd2, 4'd9, 32'd44);
    issue(2'b00, 32'd23, 32'd2, 4'd10, 32'd46);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    @(posedge clk); #1;
    check("prerst_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_res", out_res, 0);
    check("mid_rst_tag", out_tag, 0);
    exp_q.delete();
    #4 rst_n = 1'b1;
    out_ready = 1'b1;
    highs = 0;
    for (int n = 0; n < LAT + 3; n++) begin
      @(negedge clk);
      if (out_valid) highs++;
    end
    check("rst_no_stale", highs, 0);
    @(posedge clk); #1;
    issue(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd11, pick(vecs[2]));
    drain();

    // Random traffic with random CDB backpressure
    rnd_mode = 1'b1;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      op = 2'($urandom); a = $urandom; b = $urandom;
      if (n % 8 == 0) a = 32'h80000000;
      issue(op, a, b, 4'(n), model(op, a, b));
    end
    rnd_mode = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
